// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the cell has no flow control.
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // The difference bit is the odd parity of the three inputs.
   assign d    = a ^ b ^ bin;
   // A borrow is taken when b exceeds a, or when a equals b and a borrow arrives.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit subtractor: {borrow, difference} = a - b - c.
// Latency: one cycle from in_valid to out_valid, one operation per cycle.
// Backpressure: none; every valid input is accepted and a result always follows.
module full_subtractor #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             out_valid,
   output logic [WIDTH-1:0] difference,
   output logic             borrow
);

   // Borrow chain: entry 0 is the external borrow-in, entry WIDTH is the borrow-out.
   logic [WIDTH:0]   bchain;
   logic [WIDTH-1:0] d_comb;

   assign bchain[0] = c;

   // Ripple chain of single-bit cells, LSB first.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_subtractor_cell u_cell (
         .a    (a[i]),
         .b    (b[i]),
         .bin  (bchain[i]),
         .d    (d_comb[i]),
         .bout (bchain[i+1])
      );
   end

   // Output stage: capture a result on valid input, hold it while idle,
   // and clear everything immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         difference <= '0;
         borrow     <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            difference <= d_comb;
            borrow     <= bchain[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor at WIDTH=1 and WIDTH=8.
// Latency: expects results one edge after each driven vector.
// Backpressure: none; a vector is applied every cycle.
module tb_full_subtractor;

   typedef struct {
      logic vld;
      int   diff;
      int   bor;
   } exp_t;

   logic       clk;
   logic       rst_n;

   logic       iv1, a1, b1, c1;
   logic       ov1, d1, bo1;

   logic       iv8, c8;
   logic [7:0] a8, b8;
   logic       ov8, bo8;
   logic [7:0] d8;

   exp_t q1[$];
   exp_t q8[$];
   int   h1_d, h1_b, h8_d, h8_b;
   int   n_vec, n_fail;

   full_subtractor #(.WIDTH(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv1),
      .a          (a1),
      .b          (b1),
      .c          (c1),
      .out_valid  (ov1),
      .difference (d1),
      .borrow     (bo1)
   );

   full_subtractor #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (iv8),
      .a          (a8),
      .b          (b8),
      .c          (c8),
      .out_valid  (ov8),
      .difference (d8),
      .borrow     (bo8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: one result per cycle, sampled just after the active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         check("rst_w1_valid", int'(ov1), 0);
         check("rst_w1_diff", int'(d1), 0);
         check("rst_w1_borrow", int'(bo1), 0);
         check("rst_w8_valid", int'(ov8), 0);
         check("rst_w8_diff", int'(d8), 0);
         check("rst_w8_borrow", int'(bo8), 0);
      end else begin
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("w1_valid", int'(ov1), int'(e.vld));
            check("w1_diff", int'(d1), e.diff);
            check("w1_borrow", int'(bo1), e.bor);
         end
         if (q8.size() > 0) begin
            e = q8.pop_front();
            check("w8_valid", int'(ov8), int'(e.vld));
            check("w8_diff", int'(d8), e.diff);
            check("w8_borrow", int'(bo8), e.bor);
         end
      end
   end

   // Drive one cycle of stimulus on both instances and record the expected response.
   task automatic step(input logic v1, input logic ai1, input logic bi1, input logic ci1,
                       input logic v8, input logic [7:0] ai8, input logic [7:0] bi8,
                       input logic ci8);
      int full;
      @(negedge clk);
      iv1 = v1;  a1 = ai1; b1 = bi1; c1 = ci1;
      iv8 = v8;  a8 = ai8; b8 = bi8; c8 = ci8;
      if (rst_n) begin
         if (v1) begin
            full = int'(ai1) - int'(bi1) - int'(ci1);
            h1_d = full & 1;
            h1_b = (full < 0) ? 1 : 0;
         end
         q1.push_back('{v1, h1_d, h1_b});
         if (v8) begin
            full = int'(ai8) - int'(bi8) - int'(ci8);
            h8_d = full & 255;
            h8_b = (full < 0) ? 1 : 0;
         end
         q8.push_back('{v8, h8_d, h8_b});
      end
   endtask

   task automatic rand_step(input int valid_pct);
      step(1'($urandom_range(0, 99) < valid_pct), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < valid_pct), 8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic reset_models;
      q1.delete();
      q8.delete();
      h1_d = 0; h1_b = 0; h8_d = 0; h8_b = 0;
   endtask

   initial begin
      logic [2:0] abc;
      n_vec = 0; n_fail = 0;
      rst_n = 1'b0;
      iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
      reset_models();

      // Reset held with inputs toggling; the last reset cycle is idle.
      for (int i = 0; i < 4; i++) rand_step(100);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // WIDTH=1 truth table, one vector per cycle.
      for (int i = 0; i < 8; i++) begin
         abc = 3'(i);
         step(1'b1, abc[2], abc[1], abc[0], 1'b0, 8'h00, 8'h00, 1'b0);
      end

      // Hold: valid 100, then idle with 010 on the inputs.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 8'hAA, 1'b1);

      // WIDTH=8 wrap-around and boundary values.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);

      // Back-to-back stream, then reset asserted between edges.
      for (int i = 0; i < 6; i++) rand_step(100);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h01, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_w1_valid", int'(ov1), 0);
      check("async_w1_diff", int'(d1), 0);
      check("async_w1_borrow", int'(bo1), 0);
      check("async_w8_valid", int'(ov8), 0);
      check("async_w8_diff", int'(d8), 0);
      check("async_w8_borrow", int'(bo8), 0);
      reset_models();
      for (int i = 0; i < 2; i++) rand_step(100);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) rand_step(100);

      // Random traffic with occasional idle cycles.
      for (int i = 0; i < 1000; i++) rand_step(90);

      // Drain.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor computing `a - b - c`, where `c` is the borrow-in.
- Produces `difference` and `borrow` (borrow-out).
- Width-parameterised; the default `WIDTH=1` is the classic single-bit full subtractor.
- Leaf arithmetic block used in datapaths that need a pipelined subtract stage. All outputs are registered with one-cycle latency.

Parameters:
- WIDTH, 1, operand width in bits (minimum 1).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a/b/c this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in; subtracted at bit 0.
- out_valid  output  1  registered copy of in_valid.
- difference  output  WIDTH  registered `(a - b - c)` mod 2^WIDTH.
- borrow  output  1  registered borrow-out; 1 when `a < b + c` (unsigned).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - While rst_n=0, difference=0, borrow=0 and out_valid=0, independent of clk.
  - Deassertion takes effect at the next rising edge of clk.
- Bit cell i, with `bin0 = c` and `bin(i+1) = bout_i`:
  - `d_i = a_i ^ b_i ^ bin_i`
  - `bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i)`
- Outputs: difference is the concatenation of d_i; borrow is `bout(WIDTH-1)`.
- Equivalent check: `{borrow, difference} = {1'b0, a} - {1'b0, b} - c`, taken in WIDTH+1 bits as two's complement, with borrow = the MSB.
- Latency: the result of inputs sampled at rising edge N is visible after edge N. Throughput is one operation per cycle, with no stall and no backpressure.
- Hold when idle: when in_valid=0, difference and borrow keep their previous values and out_valid goes to 0.
- Wrap-around: `0 - 1` with WIDTH=1 and c=0 gives difference=1, borrow=1. `0 - 0 - 1` gives all-ones difference and borrow=1.
- Max values: `a = b = all-ones` with c=1 gives difference = all-ones and borrow=1.
- Reset asserted mid-operation clears the outputs immediately. Any in-flight result is discarded; no partial state survives.
- There are no X-propagation masks; inputs must be known whenever in_valid=1.

Decomposition:
- No shared package; the block has no typedefs, and WIDTH is the only constant.
- One natural sub-module: full_subtractor_cell, a purely combinational single-bit cell with ports a, b, bin, d, bout.
  - The top instantiates WIDTH cells in a ripple chain via a generate loop.
  - The top adds the output register stage with async active-low reset.

Test Plan:
- Reset: hold rst_n=0 with inputs toggling -> difference=0, borrow=0, out_valid=0 throughout. Release -> first valid result appears one edge after in_valid=1.
- WIDTH=1 exhaustive truth table, one vector per cycle, (a,b,c) -> (difference,borrow), each checked one cycle later with out_valid=1:
  - 000 -> 0,0
  - 001 -> 1,1
  - 010 -> 1,1
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,0
  - 110 -> 0,0
  - 111 -> 1,1
- Hold: apply 100 with in_valid=1, then in_valid=0 with inputs 010 -> difference stays 1, borrow stays 0, out_valid=0.
- WIDTH=8 wrap and boundaries:
  - a=0x00, b=0x01, c=0 -> 0xFF, borrow=1.
  - a=0x80, b=0x7F, c=1 -> 0x00, borrow=0.
  - a=0xFF, b=0xFF, c=1 -> 0xFF, borrow=1.
- Async reset mid-stream: assert rst_n=0 between clock edges during back-to-back valid vectors -> outputs clear immediately, not at the next edge. Results resume correctly after release.
- Random WIDTH=8: 1000 random (a,b,c) vectors -> every result matches `{1'b0,a} - {1'b0,b} - c` one cycle later.
